pipelined_adc: RTL and testbench
================================

Name: pipelined_adc

Overview:
- Parametrised, pipelined add/subtract-with-carry unit; successor to the single-cycle 32-bit carry adder.
- Splits the WIDTH-bit operation into SEG-bit slices, one slice per pipeline stage, with the carry rippling stage to stage.
- Uses valid/ready handshakes on input and output so it can sit between the ALU operand latch and the writeback path, with backpressure.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of SEG.
- SEG, 8, bits resolved per pipeline stage; STAGES = WIDTH/SEG (default 4).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit accepts beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry/borrow in; used only by ADC/SBB
- op  input  2  00 ADD, 01 ADC, 10 SUB, 11 SBB
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- s  output  WIDTH+1  {carry_out, sum}
- flag_z  output  1  sum == 0 (see optional feature)
- flag_v  output  1  signed overflow (see optional feature)
- flag_n  output  1  sum[WIDTH-1] (see optional feature)

Behaviour:
- Fixed interface decision: one clock, clk; reset rst is synchronous and active-high.
- Operand preparation at acceptance, when in_valid && in_ready:
  - b_eff = b for ADD/ADC; ~b for SUB/SBB.
  - c0 = 0 for ADD, cin for ADC, 1 for SUB, ~cin for SBB.
  - SBB computes A−B−cin, with cin=1 meaning borrow.
- Stage k (k = 0..STAGES−1):
  - Computes slice k as a[k] + b_eff[k] + carry_{k−1}, where carry_{−1} = c0.
  - Registers the result slice and carry_k.
  - Carries the unused upper operand slices and the op along with it.
- s[WIDTH] = final carry. For SUB/SBB this is the raw carry: 1 = no borrow.
- Latency: a beat accepted in cycle t gives out_valid in cycle t+STAGES if there are no stalls. Throughput is one beat per cycle.
- Each stage has a valid bit. Stage k advances when it is empty or stage k+1 advances. The last stage advances when out_ready is high.
- in_ready = !valid_0 || advance_0. in_ready is combinational from out_ready through the stall chain; the design has no combinational path from in_valid to in_ready.
- While out_valid=1 && out_ready=0:
  - s and the flags hold stable.
  - The pipeline compacts: bubbles fill, then the pipeline stalls.
  - No beat is lost or duplicated.
- Simultaneous events:
  - A full pipeline with out_ready=1 accepts a new beat in the same cycle the oldest one leaves.
  - Beats leave in acceptance order.
- Reset, including mid-operation:
  - All stage valids clear and in-flight beats are discarded.
  - out_valid=0, s=0, all flags=0.
  - in_ready=1 from the first cycle after rst deasserts.
- Width rules:
  - Every beat is computed exactly to WIDTH+1 bits; modular wrap-around in the sum is expected.
  - No state crosses from one beat to another. cin is the only carry chaining between operations; it is software-managed.

Optional Feature:
- Macro: PIPELINED_ADC_FLAGS_EN.
- Defined:
  - flag_z, flag_n and flag_v are registered with the final stage.
  - flag_z is the AND of per-stage slice-zero bits carried down the pipeline.
  - flag_v = (a[W−1] == b_eff[W−1]) && (sum[W−1] != a[W−1]); the operand MSBs are carried to the last stage for this.
  - All three flags obey the same hold/reset rules as s.
- Undefined:
  - The flag ports remain but are tied to 0.
  - No extra flops are added.

Test Plan:
- Defaults, ADD, a=0xFFFF_FFFF, b=0x1, out_ready=1 -> after 4 cycles s=0x1_0000_0000; flags build: z=1, v=0, n=0.
- SUB, a=5, b=7 -> s=0x0_FFFF_FFFE (carry 0 = borrow); flags build: n=1, v=0. SBB, a=7, b=5, cin=1 -> s=0x1_0000_0001.
- ADC, a=0x7FFF_FFFF, b=0, cin=1 -> s=0x0_8000_0000; flags build: v=1, n=1.
- Back-to-back: 8 consecutive beats with out_ready=1 -> 8 results on consecutive cycles, in order, starting 4 cycles after the first accept.
- Backpressure: hold out_ready=0 with 6 beats offered -> exactly 4 accepted, in_ready drops to 0, s stable. Release -> all 6 eventually delivered in order, none duplicated.
- Reset mid-flight: assert rst with 3 beats in flight -> next cycle out_valid=0, s=0, in_ready=1. No stale result appears afterwards.

Source files
------------

// File: rtl/pipelined_adc.sv
// Pipelined add/subtract-with-carry: WIDTH bits resolved SEG bits per stage, valid/ready on both sides.
// Defining PIPELINED_ADC_FLAGS_EN adds registered Z/V/N flags; otherwise the flag ports are tied low.

module pipelined_adc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   s,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n
);

    localparam int unsigned STAGES = WIDTH / SEG;
    localparam int unsigned LAST   = STAGES - 1;
    localparam int unsigned SEGW   = SEG + 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    logic [WIDTH-1:0]  w_b_eff;
    logic              w_c0;
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_adv;

    // Operand preparation: subtraction is A + ~B + c0, with SBB's borrow-in inverted into c0
    always_comb begin
        w_b_eff = b;
        w_c0    = 1'b0;
        case (op)
            OP_ADD: w_c0 = 1'b0;
            OP_ADC: w_c0 = cin;
            OP_SUB: begin
                w_b_eff = ~b;
                w_c0    = 1'b1;
            end
            default: begin
                w_b_eff = ~b;
                w_c0    = ~cin;
            end
        endcase
    end

    // Stall chain: a stage advances when empty or when its successor advances
    always_comb begin
        w_adv       = '0;
        w_adv[LAST] = !w_v[LAST] || out_ready;
        for (int k = int'(LAST) - 1; k >= 0; k--) begin
            w_adv[k] = !w_v[k] || w_adv[k+1];
        end
    end

    assign in_ready = w_adv[0];

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        localparam int unsigned IW = WIDTH - k * SEG;
        localparam int unsigned SW = (k + 1) * SEG;

        logic            w_in_v;
        logic            w_in_c;
        logic [IW-1:0]   w_in_a;
        logic [IW-1:0]   w_in_b;
        logic [SEGW-1:0] w_slice;
        logic [SW-1:0]   w_nsum;
        logic            r_v;
        logic            r_c;
        logic [SW-1:0]   r_sum;

        if (k == 0) begin : g_src
            assign w_in_v = in_valid;
            assign w_in_c = w_c0;
            assign w_in_a = a;
            assign w_in_b = w_b_eff;
            assign w_nsum = w_slice[SEG-1:0];
        end else begin : g_src
            assign w_in_v = g_stage[k-1].r_v;
            assign w_in_c = g_stage[k-1].r_c;
            assign w_in_a = g_stage[k-1].g_ops.r_a_hi;
            assign w_in_b = g_stage[k-1].g_ops.r_b_hi;
            assign w_nsum = {w_slice[SEG-1:0], g_stage[k-1].r_sum};
        end

        assign w_slice = SEGW'(w_in_a[SEG-1:0]) + SEGW'(w_in_b[SEG-1:0]) + SEGW'(w_in_c);
        assign w_v[k]  = r_v;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (w_adv[k]) begin
                r_v <= w_in_v;
                if (w_in_v) begin
                    r_c   <= w_slice[SEG];
                    r_sum <= w_nsum;
                end
            end
        end

        // Only the slices not yet consumed travel on to later stages
        if (k < int'(LAST)) begin : g_ops
            logic [IW-SEG-1:0] r_a_hi;
            logic [IW-SEG-1:0] r_b_hi;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a_hi <= '0;
                    r_b_hi <= '0;
                end else if (w_adv[k] && w_in_v) begin
                    r_a_hi <= w_in_a[IW-1:SEG];
                    r_b_hi <= w_in_b[IW-1:SEG];
                end
            end
        end

`ifdef PIPELINED_ADC_FLAGS_EN
        logic w_in_z;
        logic r_z;

        if (k == 0) begin : g_zsrc
            assign w_in_z = 1'b1;
        end else begin : g_zsrc
            assign w_in_z = g_stage[k-1].r_z;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_z <= 1'b0;
            end else if (w_adv[k] && w_in_v) begin
                r_z <= w_in_z && (w_slice[SEG-1:0] == '0);
            end
        end
`endif
    end

    assign out_valid = w_v[LAST];
    assign s         = {g_stage[LAST].r_c, g_stage[LAST].r_sum};

`ifdef PIPELINED_ADC_FLAGS_EN
    logic w_nv;
    logic r_flag_v;

    // Overflow: operands agree in sign but the result's sign differs
    assign w_nv = (g_stage[LAST].w_in_a[SEG-1] == g_stage[LAST].w_in_b[SEG-1])
               && (g_stage[LAST].w_slice[SEG-1] != g_stage[LAST].w_in_a[SEG-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag_v <= 1'b0;
        end else if (w_adv[LAST] && g_stage[LAST].w_in_v) begin
            r_flag_v <= w_nv;
        end
    end

    assign flag_z = g_stage[LAST].r_z;
    assign flag_v = r_flag_v;
    assign flag_n = g_stage[LAST].r_sum[WIDTH-1];
`else
    assign flag_z = 1'b0;
    assign flag_v = 1'b0;
    assign flag_n = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adc.sv
// Scoreboard bench for pipelined_adc: directed beats, back-to-back, backpressure and mid-flight reset.
module tb_pipelined_adc;

    localparam int unsigned WIDTH = 32;

    typedef struct packed {
        logic [WIDTH:0] s;
        logic           z;
        logic           v;
        logic           n;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   s;
    logic             flag_z;
    logic             flag_v;
    logic             flag_n;

    always #5 clk = ~clk;

    pipelined_adc #(.WIDTH(WIDTH), .SEG(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .flag_n    (flag_n)
    );

    // Hand-computed vectors: op 0=ADD 1=ADC 2=SUB 3=SBB; zvn = {z, v, n}
    logic [1:0]       v_op  [16] = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0,
                                     2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2};
    logic [WIDTH-1:0] v_a   [16] = '{32'hFFFF_FFFF, 32'd5, 32'd7, 32'h7FFF_FFFF,
                                     32'd0, 32'd3, 32'h8000_0000, 32'h0000_00FF,
                                     32'h00FF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000,
                                     32'h1234_5678, 32'h10, 32'd1, 32'd0};
    logic [WIDTH-1:0] v_b   [16] = '{32'd1, 32'd7, 32'd5, 32'd0,
                                     32'd0, 32'd3, 32'h8000_0000, 32'd1,
                                     32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1,
                                     32'h1111_1111, 32'd3, 32'd1, 32'd1};
    logic             v_cin [16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [WIDTH:0]   v_s   [16] = '{33'h1_0000_0000, 33'h0_FFFF_FFFE, 33'h1_0000_0001, 33'h0_8000_0000,
                                     33'h0_0000_0000, 33'h1_0000_0000, 33'h1_0000_0000, 33'h0_0000_0100,
                                     33'h0_0100_0000, 33'h1_0000_0000, 33'h1_FFFF_FFFF, 33'h1_7FFF_FFFF,
                                     33'h0_2345_6789, 33'h1_0000_000D, 33'h0_0000_0002, 33'h0_FFFF_FFFF};
    logic [2:0]       v_zvn [16] = '{3'b100, 3'b001, 3'b000, 3'b011, 3'b100, 3'b100, 3'b110, 3'b000,
                                     3'b000, 3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001};

    exp_t sb[$];
    int   lat_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_acc    = 0;
    int   n_out    = 0;
    bit   lat_chk  = 1'b1;
    exp_t mon_e;
    int   mon_lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t exp_for(input int idx);
        exp_t e;
        e.s = v_s[idx];
`ifdef PIPELINED_ADC_FLAGS_EN
        {e.z, e.v, e.n} = v_zvn[idx];
`else
        {e.z, e.v, e.n} = 3'b000;
`endif
        return e;
    endfunction

    // Monitor: compare every presented result against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got s=0x%0h, expected no output", s);
            end else begin
                mon_e = sb[0];
                check("result_s", 64'(s), 64'(mon_e.s));
                check("flag_z", 64'(flag_z), 64'(mon_e.z));
                check("flag_v", 64'(flag_v), 64'(mon_e.v));
                check("flag_n", 64'(flag_n), 64'(mon_e.n));
                if (out_ready) begin
                    void'(sb.pop_front());
                    mon_lat = lat_q.pop_front();
                    if (lat_chk) check("latency", 64'(cyc - mon_lat), 64'd4);
                    n_out++;
                end
            end
        end
    end

    task automatic send(input int idx);
        int waited = 0;
        in_valid = 1'b1;
        op       = v_op[idx];
        a        = v_a[idx];
        b        = v_b[idx];
        cin      = v_cin[idx];
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp_for(idx));
                lat_q.push_back(cyc);
                n_acc++;
                break;
            end
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 64'(waited), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    int c_start;
    int acc0;
    int out0;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op        = 2'b00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_s", 64'(s), 64'd0);
        check("rst_flags", 64'({flag_z, flag_v, flag_n}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Isolated beats: ADD wrap, SUB borrow, SBB, ADC overflow
        for (int i = 0; i < 4; i++) begin
            send(i);
            wait_drain();
        end

        // Back-to-back: one accept per cycle, results in order at fixed latency
        c_start = cyc;
        out0    = n_out;
        for (int i = 4; i < 12; i++) send(i);
        check("b2b_accept_cycles", 64'(cyc - c_start), 64'd8);
        wait_drain();
        check("b2b_delivered", 64'(n_out - out0), 64'd8);

        // Backpressure: only STAGES beats fit, output holds until release
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        acc0      = n_acc;
        out0      = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) send((12 + i) % 16);
            end
            begin
                repeat (12) @(posedge clk);
                #2;
                check("bp_accepted", 64'(n_acc - acc0), 64'd4);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_delivered", 64'(n_out - out0), 64'd6);

        // Reset with three beats in flight
        lat_chk = 1'b1;
        for (int i = 4; i < 7; i++) send(i);
        rst = 1'b1;
        sb.delete();
        lat_q.delete();
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_s", 64'(s), 64'd0);
        check("midrst_flags", 64'({flag_z, flag_v, flag_n}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        out0 = n_out;
        send(14);
        wait_drain();
        check("post_rst_delivered", 64'(n_out - out0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
